// File: rtl/spi_arbiter_if.sv
// Signal bundle between spi_arbiter, its byte-level requesters and the SPI master core.
interface spi_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_SLAVES_BIT = 2
);
  logic [NUM_REQ-1:0]                i_req;
  logic [8*NUM_REQ-1:0]              i_req_data;
  logic [NUM_SLAVES_BIT*NUM_REQ-1:0] i_req_ss;
  logic [NUM_REQ-1:0]                i_req_last;
  logic [NUM_REQ-1:0]                o_grant;
  logic [NUM_REQ-1:0]                o_ack;
  logic [7:0]                        o_rx_data;
  logic                              o_rx_valid;
  logic                              o_err;
  logic                              o_m_start;
  logic [7:0]                        o_m_data;
  logic [NUM_SLAVES_BIT-1:0]         o_m_ss;
  logic                              o_m_keep_ss;
  logic                              i_m_busy;
  logic                              i_m_done;
  logic [7:0]                        i_m_rx;

  // slave: the arbiter; master: the clients plus SPI core that drive it
  modport slave (
    input  i_req, i_req_data, i_req_ss, i_req_last, i_m_busy, i_m_done, i_m_rx,
    output o_grant, o_ack, o_rx_data, o_rx_valid, o_err,
           o_m_start, o_m_data, o_m_ss, o_m_keep_ss
  );

  modport master (
    output i_req, i_req_data, i_req_ss, i_req_last, i_m_busy, i_m_done, i_m_rx,
    input  o_grant, o_ack, o_rx_data, o_rx_valid, o_err,
           o_m_start, o_m_data, o_m_ss, o_m_keep_ss
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ byte requesters,
// with locked multi-byte bursts and a completion timeout watchdog.
module spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_SLAVES     = 4,
  parameter int NUM_SLAVES_BIT = 2,
  parameter int TIMEOUT        = 1024
) (
  input  logic        clk,
  input  logic        rst,
  spi_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  if (NUM_REQ < 2 || TIMEOUT < 2 ||
      NUM_SLAVES_BIT < ((NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1)) begin : g_bad_params
    $error("spi_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [7:0]                data_q, data_d;
  logic [NUM_SLAVES_BIT-1:0] ss_q, ss_d;
  logic                      last_q, last_d;
  logic                      keep_q, keep_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [7:0]                rx_q, rx_d;
  logic                      err_q, err_d;

  logic [7:0]                req_data_a [NUM_REQ];
  logic [NUM_SLAVES_BIT-1:0] req_ss_a   [NUM_REQ];
  logic                      found;
  logic [IDX_W-1:0]          pick, cand;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data_a[k] = bus.i_req_data[8*k +: 8];
    assign req_ss_a[k]   = bus.i_req_ss[NUM_SLAVES_BIT*k +: NUM_SLAVES_BIT];
  end

  // First active request strictly after the pointer, wrapping; the pointer itself is checked last.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && bus.i_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      data_q  <= '0;
      ss_q    <= '0;
      last_q  <= 1'b0;
      keep_q  <= 1'b0;
      cnt_q   <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ss_q    <= ss_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    grant_d        = grant_q;
    data_d         = data_q;
    ss_d           = ss_q;
    last_d         = last_q;
    keep_d         = keep_q;
    cnt_d          = cnt_q;
    rx_d           = rx_q;
    err_d          = err_q;
    bus.o_ack      = '0;
    bus.o_rx_valid = 1'b0;
    bus.o_rx_data  = '0;
    bus.o_err      = 1'b0;
    bus.o_m_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !bus.i_m_busy) begin
          ptr_d         = pick;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          data_d        = req_data_a[pick];
          ss_d          = req_ss_a[pick];
          last_d        = bus.i_req_last[pick];
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        bus.o_m_start = 1'b1;
        cnt_d         = '0;
        if (!last_q) keep_d = 1'b1;
        state_d       = WAIT;
      end
      WAIT: begin
        if (bus.i_m_done) begin
          rx_d    = bus.i_m_rx;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rx_d    = '0;
          err_d   = 1'b1;
          keep_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        bus.o_ack      = grant_q;
        bus.o_rx_valid = 1'b1;
        bus.o_rx_data  = rx_q;
        bus.o_err      = err_q;
        if (!last_q && bus.i_req[owner_q] && !err_q) begin
          data_d  = req_data_a[owner_q];
          ss_d    = req_ss_a[owner_q];
          last_d  = bus.i_req_last[owner_q];
          state_d = ISSUE;
        end else begin
          grant_d = '0;
          keep_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_m_data    = data_q;
  assign bus.o_m_ss      = ss_q;
  assign bus.o_m_keep_ss = keep_q;
endmodule
